// File: rtl/mux_arb_reg_if.sv
// Handshake bundle for mux_arb_reg: channel inputs, selection controls and the registered output.
// master = producers/consumer side, slave = the selector itself.
interface mux_arb_reg_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      op;
  logic [WIDTH-1:0]     y;
  logic                 y_valid;
  logic                 y_ready;
  logic [SELW-1:0]      y_ch;

  modport master (
    output in_data, in_valid, mode, op, y_ready,
    input  in_ready, y, y_valid, y_ch
  );

  modport slave (
    input  in_data, in_valid, mode, op, y_ready,
    output in_ready, y, y_valid, y_ch
  );
endinterface

// File: rtl/mux_arb_reg.sv
// N-channel selector (direct by op, or round-robin) feeding a one-word registered output stage.
// Define MUXARB_STAT_EN to add the saturating xfer_cnt output-handshake counter.
module mux_arb_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_arb_reg_if.slave bus
`ifdef MUXARB_STAT_EN
  ,
  output logic [15:0]  xfer_cnt
`endif
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [SELW-1:0]   y_ch_q, y_ch_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW-1:0]   grant;
  logic              grant_valid;
  logic              load_en;
  logic              xfer;
  logic [NCH-1:0]    in_ready_c;
  logic [WIDTH-1:0]  ch_data [NCH];

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // Round-robin scans ptr, ptr+1, ... wrapping; direct mode clamps op to the last channel.
  always_comb begin
    int              idx;
    logic [SELW-1:0] cand;
    idx         = 0;
    cand        = '0;
    grant       = '0;
    grant_valid = 1'b0;
    if (bus.mode) begin
      for (int i = 0; i < NCH; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NCH) begin
          idx = idx - NCH;
        end
        cand = SELW'(idx);
        if (!grant_valid && bus.in_valid[cand]) begin
          grant_valid = 1'b1;
          grant       = cand;
        end
      end
    end else begin
      if (int'(bus.op) >= NCH) begin
        grant = SELW'(NCH - 1);
      end else begin
        grant = bus.op;
      end
      grant_valid = bus.in_valid[grant];
    end
  end

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    y_ch_d     = y_ch_q;
    ptr_d      = ptr_q;
    in_ready_c = '0;
    load_en    = (state_q == EMPTY) || bus.y_ready;
    xfer       = load_en && grant_valid;
    if (xfer) begin
      in_ready_c[grant] = 1'b1;
      state_d           = FULL;
      y_d               = ch_data[grant];
      y_ch_d            = grant;
      if (bus.mode) begin
        ptr_d = (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;
      end
    end else if (state_q == FULL && bus.y_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      y_ch_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      y_ch_q  <= y_ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.y        = y_q;
  assign bus.y_valid  = (state_q == FULL);
  assign bus.y_ch     = y_ch_q;

`ifdef MUXARB_STAT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (state_q == FULL && bus.y_ready && xfer_cnt_q != 16'hFFFF) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`else
  // Default build carries no statistics logic.
`endif
endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed self-checking bench for mux_arb_reg: a 4-channel instance for the main scenarios
// and a 5-channel instance where an out-of-range op exercises the clamp.
module tb_mux_arb_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchecks = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  localparam logic [31:0] BASE4 = {8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [31:0] ALT4  = {8'h55, 8'h66, 8'h77, 8'h88};
  localparam logic [39:0] BASE5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

  mux_arb_reg_if #(.WIDTH(8), .NCH(4)) bus4 ();
  mux_arb_reg_if #(.WIDTH(8), .NCH(5)) bus5 ();

`ifdef MUXARB_STAT_EN
  logic [15:0] cnt4;
  logic [15:0] cnt5;
`endif

  mux_arb_reg #(.WIDTH(8), .NCH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus4)
`ifdef MUXARB_STAT_EN
    ,
    .xfer_cnt(cnt4)
`endif
  );

  // Second instance: NCH=5 leaves op codes 5..7 out of range.
  mux_arb_reg #(.WIDTH(8), .NCH(5)) dut5 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus5)
`ifdef MUXARB_STAT_EN
    ,
    .xfer_cnt(cnt5)
`endif
  );

  function automatic logic [7:0] byte4(input logic [31:0] d, input int k);
    return d[k*8 +: 8];
  endfunction

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got time %0t, required finish before it", $time);
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    nchecks++; if (bus4.y !== 8'h00) begin nfail++; $display("[TB] FAIL reset_y: got %h required 00", bus4.y); end
    nchecks++; if (bus4.y_valid !== 1'b0) begin nfail++; $display("[TB] FAIL reset_y_valid: got %b required 0", bus4.y_valid); end
    nchecks++; if (bus4.y_ch !== 2'd0) begin nfail++; $display("[TB] FAIL reset_y_ch: got %0d required 0", bus4.y_ch); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nchecks++; if (bus4.y_valid !== 1'b0) begin nfail++; $display("[TB] FAIL idle_after_reset: got %b required 0", bus4.y_valid); end
  endtask

  task automatic test_direct();
    logic [1:0] ops [3];
    ops = '{2'd0, 2'd3, 2'd1};
    bus4.in_data = BASE4; bus4.in_valid = 4'hF; bus4.mode = 1'b0; bus4.op = 2'd2; bus4.y_ready = 1'b1;
    #1;
    nchecks++; if (bus4.in_ready !== 4'b0100) begin nfail++; $display("[TB] FAIL direct_in_ready: got %b required 0100", bus4.in_ready); end
    @(negedge clk);
    nchecks++; if (bus4.y !== 8'h33) begin nfail++; $display("[TB] FAIL direct_y: got %h required 33", bus4.y); end
    nchecks++; if (bus4.y_ch !== 2'd2) begin nfail++; $display("[TB] FAIL direct_y_ch: got %0d required 2", bus4.y_ch); end
    nchecks++; if (bus4.y_valid !== 1'b1) begin nfail++; $display("[TB] FAIL direct_y_valid: got %b required 1", bus4.y_valid); end
    for (int i = 0; i < 3; i++) begin
      bus4.op = ops[i];
      #1;
      nchecks++; if (bus4.in_ready !== (4'b0001 << ops[i])) begin nfail++; $display("[TB] FAIL direct_seq_in_ready: got %b required %b", bus4.in_ready, 4'b0001 << ops[i]); end
      @(negedge clk);
      nchecks++; if (bus4.y !== byte4(BASE4, int'(ops[i]))) begin nfail++; $display("[TB] FAIL direct_seq_y: got %h required %h", bus4.y, byte4(BASE4, int'(ops[i]))); end
      nchecks++; if (bus4.y_ch !== ops[i]) begin nfail++; $display("[TB] FAIL direct_seq_y_ch: got %0d required %0d", bus4.y_ch, ops[i]); end
    end
    bus4.op = 2'd2; bus4.in_valid = 4'b1011;
    #1;
    nchecks++; if (bus4.in_ready !== 4'b0000) begin nfail++; $display("[TB] FAIL direct_unselected_in_ready: got %b required 0000", bus4.in_ready); end
    @(negedge clk);
    nchecks++; if (bus4.y_valid !== 1'b0) begin nfail++; $display("[TB] FAIL direct_drain_y_valid: got %b required 0", bus4.y_valid); end
  endtask

  task automatic test_round_robin();
    int exp_g;
    bus4.in_data = BASE4; bus4.in_valid = 4'hF; bus4.mode = 1'b1; bus4.y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_g = i % 4;
      #1;
      nchecks++; if (bus4.in_ready !== (4'b0001 << exp_g)) begin nfail++; $display("[TB] FAIL rr_in_ready: got %b required %b", bus4.in_ready, 4'b0001 << exp_g); end
      @(negedge clk);
      nchecks++; if (bus4.y_ch !== 2'(exp_g)) begin nfail++; $display("[TB] FAIL rr_y_ch: got %0d required %0d", bus4.y_ch, exp_g); end
      nchecks++; if (bus4.y !== byte4(BASE4, exp_g)) begin nfail++; $display("[TB] FAIL rr_y: got %h required %h", bus4.y, byte4(BASE4, exp_g)); end
    end
  endtask

  task automatic test_backpressure();
    bus4.mode = 1'b0; bus4.op = 2'd1; bus4.in_valid = 4'hF; bus4.y_ready = 1'b1;
    #1;
    nchecks++; if (bus4.in_ready !== 4'b0010) begin nfail++; $display("[TB] FAIL bp_load_in_ready: got %b required 0010", bus4.in_ready); end
    @(negedge clk);
    nchecks++; if (bus4.y !== 8'h22) begin nfail++; $display("[TB] FAIL bp_load_y: got %h required 22", bus4.y); end
    bus4.y_ready = 1'b0; bus4.op = 2'd3; bus4.in_data = ALT4;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchecks++; if (bus4.in_ready !== 4'b0000) begin nfail++; $display("[TB] FAIL bp_stall_in_ready: got %b required 0000", bus4.in_ready); end
      @(negedge clk);
      nchecks++; if (bus4.y !== 8'h22) begin nfail++; $display("[TB] FAIL bp_hold_y: got %h required 22", bus4.y); end
      nchecks++; if (bus4.y_ch !== 2'd1) begin nfail++; $display("[TB] FAIL bp_hold_y_ch: got %0d required 1", bus4.y_ch); end
      nchecks++; if (bus4.y_valid !== 1'b1) begin nfail++; $display("[TB] FAIL bp_hold_y_valid: got %b required 1", bus4.y_valid); end
    end
    bus4.y_ready = 1'b1;
    #1;
    nchecks++; if (bus4.in_ready !== 4'b1000) begin nfail++; $display("[TB] FAIL bp_release_in_ready: got %b required 1000", bus4.in_ready); end
    @(negedge clk);
    nchecks++; if (bus4.y !== 8'h55) begin nfail++; $display("[TB] FAIL bp_release_y: got %h required 55", bus4.y); end
    nchecks++; if (bus4.y_ch !== 2'd3) begin nfail++; $display("[TB] FAIL bp_release_y_ch: got %0d required 3", bus4.y_ch); end
    bus4.in_data = BASE4;
  endtask

  task automatic test_rr_sparse();
    logic [1:0] order [3];
    order = '{2'd3, 2'd1, 2'd3};
    // A lone ch1 grant leaves the pointer at 2.
    bus4.mode = 1'b1; bus4.in_valid = 4'b0010; bus4.y_ready = 1'b1;
    #1;
    nchecks++; if (bus4.in_ready !== 4'b0010) begin nfail++; $display("[TB] FAIL sparse_prime_in_ready: got %b required 0010", bus4.in_ready); end
    @(negedge clk);
    nchecks++; if (bus4.y_ch !== 2'd1) begin nfail++; $display("[TB] FAIL sparse_prime_y_ch: got %0d required 1", bus4.y_ch); end
    bus4.in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchecks++; if (bus4.in_ready !== (4'b0001 << order[i])) begin nfail++; $display("[TB] FAIL sparse_in_ready: got %b required %b", bus4.in_ready, 4'b0001 << order[i]); end
      @(negedge clk);
      nchecks++; if (bus4.y_ch !== order[i]) begin nfail++; $display("[TB] FAIL sparse_y_ch: got %0d required %0d", bus4.y_ch, order[i]); end
    end
    bus4.mode = 1'b0; bus4.op = 2'd3;
    #1;
    nchecks++; if (bus4.in_ready !== 4'b1000) begin nfail++; $display("[TB] FAIL sparse_direct_in_ready: got %b required 1000", bus4.in_ready); end
    @(negedge clk);
    nchecks++; if (bus4.y !== 8'h44) begin nfail++; $display("[TB] FAIL sparse_direct_y: got %h required 44", bus4.y); end
    bus4.in_valid = 4'b0000;
  endtask

  task automatic test_clamp();
    logic [2:0] ops [3];
    ops = '{3'd5, 3'd7, 3'd4};
    bus5.in_data = BASE5; bus5.in_valid = 5'h1F; bus5.mode = 1'b0; bus5.y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus5.op = ops[i];
      #1;
      nchecks++; if (bus5.in_ready !== 5'b10000) begin nfail++; $display("[TB] FAIL clamp_in_ready: got %b required 10000", bus5.in_ready); end
      @(negedge clk);
      nchecks++; if (bus5.y !== 8'h55) begin nfail++; $display("[TB] FAIL clamp_y: got %h required 55", bus5.y); end
      nchecks++; if (bus5.y_ch !== 3'd4) begin nfail++; $display("[TB] FAIL clamp_y_ch: got %0d required 4", bus5.y_ch); end
    end
    bus5.op = 3'd6; bus5.in_valid = 5'b01111;
    #1;
    nchecks++; if (bus5.in_ready !== 5'b00000) begin nfail++; $display("[TB] FAIL clamp_invalid_in_ready: got %b required 00000", bus5.in_ready); end
    @(negedge clk);
    nchecks++; if (bus5.y_valid !== 1'b0) begin nfail++; $display("[TB] FAIL clamp_invalid_y_valid: got %b required 0", bus5.y_valid); end
    bus5.in_valid = '0; bus5.y_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus4.mode = 1'b1; bus4.in_valid = 4'b0010; bus4.y_ready = 1'b1;
    @(negedge clk);
    nchecks++; if (bus4.y_ch !== 2'd1) begin nfail++; $display("[TB] FAIL midrst_prime_y_ch: got %0d required 1", bus4.y_ch); end
    bus4.y_ready = 1'b0; bus4.in_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    nchecks++; if (bus4.y !== 8'h00) begin nfail++; $display("[TB] FAIL midrst_y: got %h required 00", bus4.y); end
    nchecks++; if (bus4.y_valid !== 1'b0) begin nfail++; $display("[TB] FAIL midrst_y_valid: got %b required 0", bus4.y_valid); end
    nchecks++; if (bus4.y_ch !== 2'd0) begin nfail++; $display("[TB] FAIL midrst_y_ch: got %0d required 0", bus4.y_ch); end
    @(negedge clk);
    nchecks++; if (bus4.y_valid !== 1'b0) begin nfail++; $display("[TB] FAIL midrst_hold_y_valid: got %b required 0", bus4.y_valid); end
    rst_n = 1'b1;
    bus4.y_ready = 1'b1;
    #1;
    nchecks++; if (bus4.in_ready !== 4'b0001) begin nfail++; $display("[TB] FAIL midrst_ptr_in_ready: got %b required 0001", bus4.in_ready); end
    @(negedge clk);
    nchecks++; if (bus4.y_ch !== 2'd0) begin nfail++; $display("[TB] FAIL midrst_ptr_y_ch: got %0d required 0", bus4.y_ch); end
    nchecks++; if (bus4.y !== 8'h11) begin nfail++; $display("[TB] FAIL midrst_ptr_y: got %h required 11", bus4.y); end
  endtask

  task automatic test_back_to_back();
    int edges;
    rst_n = 1'b0;
    bus4.in_data = BASE4; bus4.in_valid = 4'hF; bus4.mode = 1'b1; bus4.y_ready = 1'b1;
    #1;
`ifdef MUXARB_STAT_EN
    nchecks++; if (cnt4 !== 16'h0000) begin nfail++; $display("[TB] FAIL cnt_reset: got %h required 0000", cnt4); end
    edges = 70000;
`else
    edges = 12;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= edges; e++) begin
      @(negedge clk);
      if (e <= 12) begin
        nchecks++; if (bus4.y_valid !== 1'b1) begin nfail++; $display("[TB] FAIL b2b_y_valid: got %b required 1", bus4.y_valid); end
        nchecks++; if (bus4.y_ch !== 2'((e - 1) % 4)) begin nfail++; $display("[TB] FAIL b2b_y_ch: got %0d required %0d", bus4.y_ch, (e - 1) % 4); end
      end
`ifdef MUXARB_STAT_EN
      if (e == 10 || e == 65535 || e == 65536 || e == 70000) begin
        nchecks++;
        if (cnt4 !== ((e - 1 > 65535) ? 16'hFFFF : 16'(e - 1))) begin
          nfail++;
          $display("[TB] FAIL cnt_value: got %h required %h after %0d edges", cnt4, (e - 1 > 65535) ? 16'hFFFF : 16'(e - 1), e);
        end
      end
`endif
    end
  endtask

  initial begin
    bus4.in_data = BASE4; bus4.in_valid = '0; bus4.mode = 1'b0; bus4.op = '0; bus4.y_ready = 1'b0;
    bus5.in_data = BASE5; bus5.in_valid = '0; bus5.mode = 1'b0; bus5.op = '0; bus5.y_ready = 1'b0;
    test_reset();
    test_direct();
    test_round_robin();
    test_backpressure();
    test_rr_sparse();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end
endmodule
